ace_instbuf: RTL and testbench
==============================

Name: ace_instbuf

Overview:
- Decode stage-0 instruction buffer: circular FIFO of 32-bit instructions between the fetch unit's d0 registers and the decoder.
- Enqueues up to 8 instructions per cycle from fetch and presents the 4 oldest in program order to decode.
- Drives instbuf_full_o back to fetch-stage pipeline control.
- Retire flush empties the buffer.

Parameters:
DEPTH, 32, entry count; power of two, >= 24
DEQ_W, 4, decode presentation width; fixed at 4

Ports:
clock  in  1  core clock
reset_n  in  1  reset
inst0_vld_i..inst7_vld_i  in  1 each  fetch d0 valid bits
inst0_i..inst7_i  in  32 each  fetch d0 instructions (slot 0 oldest)
flush_i  in  1  retire flush (same signal fetch receives as flush_rt_i)
dec_take_i  in  3  number of presented instructions decode consumes this cycle (0..4)
dq0_vld_o..dq3_vld_o  out  1 each  presented-slot valid
dq0_o..dq3_o  out  32 each  presented instructions (dq0 oldest)
instbuf_full_o  out  1  backpressure to fetch
instbuf_empty_o  out  1  occupancy == 0
instbuf_cnt_o  out  log2(DEPTH)+1  occupancy

Behaviour:
- Clock and reset: single clock `clock`. `reset_n` is asynchronous and active-low.
- Reset values:
  - rd_ptr = wr_ptr = cnt = 0.
  - enq_ok_r = 1.
  - instbuf_full_o = 0, instbuf_empty_o = 1, instbuf_cnt_o = 0.
  - All dq*_vld_o = 0 and all dq*_o = 0.
  - Storage array is not reset.
- State: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap modulo DEPTH. cnt is log2(DEPTH)+1 bits.
- Enqueue qualification:
  - Fetch holds its d0 registers while stalled, so a held group must not be enqueued twice.
  - Register enq_ok_r <= ~instbuf_full_o | flush_i. It is 1 exactly when fetch loaded its d0 registers at the previous edge.
  - enq_n = number of leading ones in inst_vld[7:0], counted from bit 0. Bits above the first zero are ignored.
  - Effective enqueue count = enq_ok_r & ~flush_i ? enq_n : 0.
- Enqueue write:
  - Slot k (k < enq_n) writes storage[wr_ptr+k mod DEPTH].
  - Then wr_ptr += enq_n.
- Dequeue:
  - deq_n = min(dec_take_i, cnt, 4).
  - rd_ptr += deq_n.
  - dec_take_i > 4 or > cnt is clamped silently.
- Occupancy update: cnt <= cnt + enq_n - deq_n. Enqueue and dequeue in the same cycle are both honoured.
- Presentation (combinational from registered state):
  - dqk_vld_o = (cnt > k).
  - dqk_o = storage[rd_ptr+k] when valid, else 0.
  - No write-to-read bypass: enqueued data is visible the cycle after the write edge.
- Full threshold:
  - A group committed by fetch arrives one cycle later, and one further group may already be in flight, so 16 free entries are always reserved.
  - instbuf_full_o = (DEPTH - cnt) < 16, computed from the registered cnt.
  - Overflow is therefore impossible under legal fetch behaviour. Any write that would exceed DEPTH is an assertion failure in simulation.
- Flush (flush_i = 1) at edge:
  - rd_ptr, wr_ptr and cnt go to 0.
  - The incoming group and the dequeue are both discarded.
  - enq_ok_r <= 1.
  - Next cycle: outputs all invalid, empty = 1, full = 0.
  - Flush has priority over all simultaneous events.
- Wrap-around: writes and reads straddling index DEPTH-1 -> 0 stay in program order.
- Reset asserted mid-operation returns all state to reset values immediately. Buffered instructions are lost.

Test Plan:
- Reset, then one group with vld = 8'hFF, inst k = 32'h1000_000k, dec_take = 0 -> next cycle cnt = 8, dq0..dq3 = 0x10000000..0x10000003, all dq*_vld = 1, full = 0.
- vld = 8'h07 then vld = 8'h0B (prefix length 2) -> cnt = 5. Slot 3 of the second group is ignored. Order: g1[0..2], g2[0..1].
- Fill to cnt = 17 with dec_take = 0 -> full = 1 the cycle after cnt reaches 17.
  - Fetch holds the same valid group for 3 cycles -> cnt grows by exactly one group, from the single cycle where enq_ok_r = 1.
- cnt = 3 with dec_take = 4 -> deq_n clamps to 3, cnt = 0, empty = 1. With a simultaneous 8-wide enqueue -> cnt = 8.
- Start rd_ptr = wr_ptr = 28, enqueue 8 -> entries at 28..31, 0..3.
  - Four dequeue cycles of dec_take = 4 (cycles 1 and 2 present the 8 valid entries in order, cycles 3 and 4 take nothing) -> ptrs end at 4, cnt = 0.
- cnt = 20 with flush_i, an 8-wide enqueue and dec_take = 2 in the same cycle -> next cycle cnt = 0, empty = 1, full = 0, no dq valid. The following fetch group is enqueued normally.

Source files
------------

// File: rtl/ace_instbuf_if.sv
// Fetch/decode-facing bundle of the decode stage-0 instruction buffer.
// The buffer side uses the slave modport; the fetch/decode side uses master.
interface ace_instbuf_if #(
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic           inst0_vld_i, inst1_vld_i, inst2_vld_i, inst3_vld_i;
  logic           inst4_vld_i, inst5_vld_i, inst6_vld_i, inst7_vld_i;
  logic [31:0]    inst0_i, inst1_i, inst2_i, inst3_i;
  logic [31:0]    inst4_i, inst5_i, inst6_i, inst7_i;
  logic           flush_i;
  logic [2:0]     dec_take_i;
  logic           dq0_vld_o, dq1_vld_o, dq2_vld_o, dq3_vld_o;
  logic [31:0]    dq0_o, dq1_o, dq2_o, dq3_o;
  logic           instbuf_full_o;
  logic           instbuf_empty_o;
  logic [CW-1:0]  instbuf_cnt_o;

  modport slave (
    input  inst0_vld_i, inst1_vld_i, inst2_vld_i, inst3_vld_i,
           inst4_vld_i, inst5_vld_i, inst6_vld_i, inst7_vld_i,
           inst0_i, inst1_i, inst2_i, inst3_i,
           inst4_i, inst5_i, inst6_i, inst7_i,
           flush_i, dec_take_i,
    output dq0_vld_o, dq1_vld_o, dq2_vld_o, dq3_vld_o,
           dq0_o, dq1_o, dq2_o, dq3_o,
           instbuf_full_o, instbuf_empty_o, instbuf_cnt_o
  );

  modport master (
    output inst0_vld_i, inst1_vld_i, inst2_vld_i, inst3_vld_i,
           inst4_vld_i, inst5_vld_i, inst6_vld_i, inst7_vld_i,
           inst0_i, inst1_i, inst2_i, inst3_i,
           inst4_i, inst5_i, inst6_i, inst7_i,
           flush_i, dec_take_i,
    input  dq0_vld_o, dq1_vld_o, dq2_vld_o, dq3_vld_o,
           dq0_o, dq1_o, dq2_o, dq3_o,
           instbuf_full_o, instbuf_empty_o, instbuf_cnt_o
  );
endinterface

// File: rtl/ace_instbuf.sv
// Decode stage-0 instruction buffer: circular FIFO taking up to 8 fetched
// instructions per cycle and presenting the 4 oldest to decode in order.
module ace_instbuf #(
  parameter int DEPTH = 32,
  parameter int DEQ_W = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  ace_instbuf_if.slave  ib
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_AT = CW'(DEPTH - 16);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enq_ok_q, enq_ok_d;

  logic [7:0]    inst_vld;
  logic [31:0]   inst [8];
  logic [3:0]    enq_n;
  logic [3:0]    enq_cnt;
  logic [CW-1:0] deq_n;
  logic          full;
  logic [PW-1:0] wr_addr [8];
  logic [DEQ_W-1:0] dq_vld;
  logic [31:0]   dq [DEQ_W];

  assign inst_vld = {ib.inst7_vld_i, ib.inst6_vld_i, ib.inst5_vld_i, ib.inst4_vld_i,
                     ib.inst3_vld_i, ib.inst2_vld_i, ib.inst1_vld_i, ib.inst0_vld_i};
  assign inst[0] = ib.inst0_i;
  assign inst[1] = ib.inst1_i;
  assign inst[2] = ib.inst2_i;
  assign inst[3] = ib.inst3_i;
  assign inst[4] = ib.inst4_i;
  assign inst[5] = ib.inst5_i;
  assign inst[6] = ib.inst6_i;
  assign inst[7] = ib.inst7_i;

  // Only the contiguous run of valid slots starting at slot 0 is taken;
  // a held fetch group (enq_ok_q low) must not be written a second time.
  always_comb begin
    enq_n = '0;
    for (int k = 0; k < 8; k++) begin
      if (inst_vld[k] && (enq_n == 4'(k))) enq_n = 4'(k + 1);
    end
    enq_cnt = (enq_ok_q && !ib.flush_i) ? enq_n : '0;
    for (int k = 0; k < 8; k++) begin
      wr_addr[k] = wr_ptr_q + PW'(k);
    end
  end

  always_comb begin
    deq_n = CW'(ib.dec_take_i);
    if (deq_n > CW'(DEQ_W)) deq_n = CW'(DEQ_W);
    if (deq_n > cnt_q)      deq_n = cnt_q;
  end

  // 16 free entries are held back for the group in the d0 registers plus one in flight.
  assign full = (cnt_q > FULL_AT);

  always_comb begin
    enq_ok_d = !full || ib.flush_i;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (ib.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(deq_n);
      wr_ptr_d = wr_ptr_q + PW'(enq_cnt);
      cnt_d    = cnt_q + CW'(enq_cnt) - deq_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      enq_ok_q <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      enq_ok_q <= enq_ok_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < enq_cnt) mem_q[wr_addr[k]] <= inst[k];
    end
  end

  always_comb begin
    for (int k = 0; k < DEQ_W; k++) begin
      dq_vld[k] = (cnt_q > CW'(k));
      dq[k]     = dq_vld[k] ? mem_q[rd_ptr_q + PW'(k)] : '0;
    end
  end

  assign ib.dq0_vld_o       = dq_vld[0];
  assign ib.dq1_vld_o       = dq_vld[1];
  assign ib.dq2_vld_o       = dq_vld[2];
  assign ib.dq3_vld_o       = dq_vld[3];
  assign ib.dq0_o           = dq[0];
  assign ib.dq1_o           = dq[1];
  assign ib.dq2_o           = dq[2];
  assign ib.dq3_o           = dq[3];
  assign ib.instbuf_full_o  = full;
  assign ib.instbuf_empty_o = (cnt_q == '0);
  assign ib.instbuf_cnt_o   = cnt_q;

  overflow_chk: assert property (@(posedge clock) disable iff (!reset_n)
    ({1'b0, cnt_q} + (CW+1)'(enq_cnt)) <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_ace_instbuf.sv
// Self-checking bench for ace_instbuf: directed scenarios plus randomized
// traffic, compared every cycle against a queue-based reference model.
module tb_ace_instbuf;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mq [$];
  bit          enq_ok_m = 1'b1;

  ace_instbuf_if #(.DEPTH(DEPTH)) ib ();

  ace_instbuf #(.DEPTH(DEPTH), .DEQ_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ib      (ib)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    int sz;
    logic [31:0] dq_got [4];
    logic        vld_got [4];
    sz = mq.size();
    dq_got[0] = ib.dq0_o;  dq_got[1] = ib.dq1_o;
    dq_got[2] = ib.dq2_o;  dq_got[3] = ib.dq3_o;
    vld_got[0] = ib.dq0_vld_o; vld_got[1] = ib.dq1_vld_o;
    vld_got[2] = ib.dq2_vld_o; vld_got[3] = ib.dq3_vld_o;
    checkOutput({tag, ".cnt"},   32'(ib.instbuf_cnt_o), 32'(sz));
    checkOutput({tag, ".empty"}, 32'(ib.instbuf_empty_o), 32'(sz == 0));
    checkOutput({tag, ".full"},  32'(ib.instbuf_full_o), 32'((DEPTH - sz) < 16));
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s.vld%0d", tag, k), 32'(vld_got[k]), 32'(k < sz));
      checkOutput($sformatf("%s.dq%0d", tag, k), dq_got[k], (k < sz) ? mq[k] : 32'h0);
    end
  endtask

  task automatic driveInputs(input logic [7:0] vld, input logic [31:0] base,
                             input logic [2:0] take, input logic flush);
    {ib.inst7_vld_i, ib.inst6_vld_i, ib.inst5_vld_i, ib.inst4_vld_i,
     ib.inst3_vld_i, ib.inst2_vld_i, ib.inst1_vld_i, ib.inst0_vld_i} = vld;
    ib.inst0_i = base;      ib.inst1_i = base + 1;
    ib.inst2_i = base + 2;  ib.inst3_i = base + 3;
    ib.inst4_i = base + 4;  ib.inst5_i = base + 5;
    ib.inst6_i = base + 6;  ib.inst7_i = base + 7;
    ib.dec_take_i = take;
    ib.flush_i = flush;
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic applyStimulus(input string tag, input logic [7:0] vld, input logic [31:0] base,
                               input logic [2:0] take, input logic flush);
    bit full_prev;
    int deq;
    driveInputs(vld, base, take, flush);
    @(posedge clock);
    #1;
    full_prev = (DEPTH - mq.size()) < 16;
    if (flush) begin
      mq.delete();
      enq_ok_m = 1'b1;
    end else begin
      deq = int'(take);
      if (deq > 4) deq = 4;
      if (deq > mq.size()) deq = mq.size();
      repeat (deq) void'(mq.pop_front());
      if (enq_ok_m) begin
        for (int k = 0; k < 8; k++) begin
          if (!vld[k]) break;
          mq.push_back(base + 32'(k));
        end
      end
      enq_ok_m = !full_prev;
    end
    checkAll(tag);
  endtask

  initial begin
    logic [7:0]  rvld;
    logic [31:0] rbase;
    logic [2:0]  rtake;
    logic        rflush;

    driveInputs(8'h00, 32'h0, 3'd0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    checkAll("reset");
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus("grp8", 8'hFF, 32'h1000_0000, 3'd0, 1'b0);

    applyStimulus("fl1", 8'h00, 32'h0, 3'd0, 1'b1);
    applyStimulus("pre3", 8'h07, 32'h2000_0000, 3'd0, 1'b0);
    applyStimulus("pre2", 8'h0B, 32'h3000_0000, 3'd0, 1'b0);

    applyStimulus("fl2", 8'h00, 32'h0, 3'd0, 1'b1);
    applyStimulus("fill8", 8'hFF, 32'h4000_0000, 3'd0, 1'b0);
    applyStimulus("fill16", 8'hFF, 32'h4100_0000, 3'd0, 1'b0);
    applyStimulus("fill17", 8'h01, 32'h4200_0000, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("hold%0d", i), 8'hFF, 32'h4300_0000, 3'd0, 1'b0);

    applyStimulus("fl3", 8'h00, 32'h0, 3'd0, 1'b1);
    applyStimulus("c3", 8'h07, 32'h5000_0000, 3'd0, 1'b0);
    applyStimulus("clamp", 8'h00, 32'h0, 3'd4, 1'b0);
    applyStimulus("c3b", 8'h07, 32'h5100_0000, 3'd0, 1'b0);
    applyStimulus("clampenq", 8'hFF, 32'h5200_0000, 3'd4, 1'b0);

    applyStimulus("fl4", 8'h00, 32'h0, 3'd0, 1'b1);
    for (int i = 0; i < 7; i++)
      applyStimulus($sformatf("adv%0d", i), 8'h0F, 32'h6000_0000 + 32'(i * 16), 3'd4, 1'b0);
    applyStimulus("drain", 8'h00, 32'h0, 3'd4, 1'b0);
    applyStimulus("wrapenq", 8'hFF, 32'h7000_0000, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus($sformatf("wrapdeq%0d", i), 8'h00, 32'h0, 3'd4, 1'b0);

    applyStimulus("fl5", 8'h00, 32'h0, 3'd0, 1'b1);
    applyStimulus("c8", 8'hFF, 32'h8000_0000, 3'd0, 1'b0);
    applyStimulus("c16", 8'hFF, 32'h8100_0000, 3'd0, 1'b0);
    applyStimulus("c20", 8'h0F, 32'h8200_0000, 3'd0, 1'b0);
    applyStimulus("flushall", 8'hFF, 32'h8300_0000, 3'd2, 1'b1);
    applyStimulus("postfl", 8'hFF, 32'h8400_0000, 3'd0, 1'b0);

    // Fetch-like random traffic: a group is held while the buffer reports full.
    rvld = 8'h00;
    rbase = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (!((DEPTH - mq.size()) < 16)) begin
        rvld  = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 255))) :
                8'((1 << $urandom_range(0, 8)) - 1);
        rbase = $urandom;
      end
      rtake  = 3'($urandom_range(0, 7));
      rflush = ($urandom_range(0, 31) == 0);
      applyStimulus($sformatf("rnd%0d", i), rvld, rbase, rtake, rflush);
    end

    applyStimulus("prerst", 8'hFF, 32'h9000_0000, 3'd0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    enq_ok_m = 1'b1;
    checkAll("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus("postrst", 8'h3F, 32'hA000_0000, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
